// File: rtl/countdown_timer_if.sv
// Handshake bundle between mode_control (master) and countdown_timer (slave).
interface countdown_timer_if;
  logic       tick;
  logic       select;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       wrap;
  logic       done;

  modport master (
    output tick, select, load, load_min, load_sec,
    input  min_bcd, sec_bcd, wrap, done
  );

  modport slave (
    input  tick, select, load, load_min, load_sec,
    output min_bcd, sec_bcd, wrap, done
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD mm:ss up/down counter with rollover pulse and expiry flag.
module countdown_timer #(
  parameter logic [7:0] PRESET_MIN = 8'h00,
  parameter logic [7:0] PRESET_SEC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned BW = 8;

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   min_q, min_d;
  logic [BW-1:0]   sec_q, sec_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;
  logic [2*BW-1:0] inc_val_c;
  logic [2*BW-1:0] dec_val_c;
  logic            at_zero_c;
  logic            at_max_c;

  // Saturate each digit of a BCD byte to the legal range of a mm/ss field.
  function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
    logic [DW-1:0] t;
    logic [DW-1:0] o;
    t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, o};
  endfunction

  // One-second increment of {mm,ss} with ripple carry; 59:59 rolls to 00:00.
  function automatic logic [2*BW-1:0] inc_mmss(input logic [2*BW-1:0] v);
    logic [DW-1:0] mt, mo, st, so;
    logic          c;
    {mt, mo, st, so} = v;
    c = 1'b1;
    if (so == 4'd9) so = 4'd0; else begin so = so + 4'd1; c = 1'b0; end
    if (c) begin
      if (st == 4'd5) st = 4'd0; else begin st = st + 4'd1; c = 1'b0; end
    end
    if (c) begin
      if (mo == 4'd9) mo = 4'd0; else begin mo = mo + 4'd1; c = 1'b0; end
    end
    if (c) begin
      if (mt == 4'd5) mt = 4'd0; else mt = mt + 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  // One-second decrement of {mm,ss} with ripple borrow; caller excludes 00:00.
  function automatic logic [2*BW-1:0] dec_mmss(input logic [2*BW-1:0] v);
    logic [DW-1:0] mt, mo, st, so;
    logic          b;
    {mt, mo, st, so} = v;
    b = 1'b1;
    if (so == 4'd0) so = 4'd9; else begin so = so - 4'd1; b = 1'b0; end
    if (b) begin
      if (st == 4'd0) st = 4'd5; else begin st = st - 4'd1; b = 1'b0; end
    end
    if (b) begin
      if (mo == 4'd0) mo = 4'd9; else begin mo = mo - 4'd1; b = 1'b0; end
    end
    if (b) begin
      if (mt == 4'd0) mt = 4'd5; else mt = mt - 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  // Shared count arithmetic for the next-state logic.
  always_comb begin
    inc_val_c = inc_mmss({min_q, sec_q});
    dec_val_c = dec_mmss({min_q, sec_q});
    at_zero_c = ({min_q, sec_q} == 16'h0000);
    at_max_c  = ({min_q, sec_q} == 16'h5959);
  end

  // State and output registers; reset reloads the preset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      min_q   <= PRESET_MIN;
      sec_q   <= PRESET_SEC;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Next state: load beats tick beats hold.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      min_d   = clamp_bcd(bus.load_min);
      sec_d   = clamp_bcd(bus.load_sec);
      state_d = RUN;
    end else if (bus.tick) begin
      if (bus.select) begin
        {min_d, sec_d} = inc_val_c;
        wrap_d         = at_max_c;
        state_d        = RUN;
      end else if (state_q == RUN) begin
        if (at_zero_c) begin
          state_d = DONE;
        end else begin
          {min_d, sec_d} = dec_val_c;
          if (dec_val_c == 16'h0000) state_d = DONE;
        end
      end
    end
    done_d = (state_d == DONE);
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: seconds-count model plus directed vectors.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  countdown_timer_if bus ();

  countdown_timer #(
    .PRESET_MIN (8'h00),
    .PRESET_SEC (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the count is an integer number of seconds 0..3599.
  int m_val;
  bit m_done;
  bit m_wrap;

  function automatic int bcd_field(input logic [7:0] v);
    int t;
    int o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 5) t = 5;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int m;
    int s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val  = 0;
      m_done = 1'b0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (bus.load) begin
        m_val  = bcd_field(bus.load_min) * 60 + bcd_field(bus.load_sec);
        m_done = 1'b0;
      end else if (bus.tick) begin
        if (bus.select) begin
          if (m_val == 3599) begin
            m_val  = 0;
            m_wrap = 1'b1;
          end else begin
            m_val = m_val + 1;
          end
          m_done = 1'b0;
        end else if (!m_done) begin
          if (m_val != 0) m_val = m_val - 1;
          if (m_val == 0) m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] e;
      e = to_bcd(m_val);
      chk("model_min",  bus.min_bcd, e[15:8]);
      chk("model_sec",  bus.sec_bcd, e[7:0]);
      chk("model_wrap", 8'(bus.wrap), 8'(m_wrap));
      chk("model_done", 8'(bus.done), 8'(m_done));
    end
  end

  // Hand-computed literal expectation.
  task automatic lit(input string tag, input logic [7:0] em, input logic [7:0] es,
                     input logic ew, input logic ed);
    chk({tag, "_min"},  bus.min_bcd, em);
    chk({tag, "_sec"},  bus.sec_bcd, es);
    chk({tag, "_wrap"}, 8'(bus.wrap), 8'(ew));
    chk({tag, "_done"}, 8'(bus.done), 8'(ed));
  endtask

  // Drive one cycle of inputs at a falling edge; return at the next falling edge.
  task automatic cyc(input bit tk, input bit sel, input bit ld,
                     input logic [7:0] lm, input logic [7:0] ls);
    bus.tick     = tk;
    bus.select   = sel;
    bus.load     = ld;
    bus.load_min = lm;
    bus.load_sec = ls;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.tick = 1'b0;
    bus.load = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    chk_en       = 1'b0;
    reset        = 1'b1;
    bus.tick     = 1'b0;
    bus.select   = 1'b0;
    bus.load     = 1'b0;
    bus.load_min = 8'h00;
    bus.load_sec = 8'h00;

    #1;
    lit("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single up tick from the preset.
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("up1", 8'h00, 8'h01, 1'b0, 1'b0);

    // Rollover with continuous tick.
    cyc(0, 1, 1, 8'h59, 8'h58);
    lit("ld5958", 8'h59, 8'h58, 1'b0, 1'b0);
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("up5959", 8'h59, 8'h59, 1'b0, 1'b0);
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("wrap", 8'h00, 8'h00, 1'b1, 1'b0);
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("postwrap", 8'h00, 8'h01, 1'b0, 1'b0);

    // Down-count with borrow across minutes.
    cyc(0, 0, 1, 8'h01, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("dn0059", 8'h00, 8'h59, 1'b0, 1'b0);
    cyc(0, 0, 1, 8'h00, 8'h01);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("dndone", 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("dnhold", 8'h00, 8'h00, 1'b0, 1'b1);

    // Loading 00:00 clears done; a down tick expires without change; up tick resumes.
    cyc(0, 0, 1, 8'h00, 8'h00);
    lit("ld0000", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("zerodn", 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("doneup", 8'h00, 8'h01, 1'b0, 1'b0);

    // Clamped load with a simultaneous tick.
    cyc(1, 1, 1, 8'h7C, 8'h9A);
    lit("clamp", 8'h59, 8'h59, 1'b0, 1'b0);

    // Fast-mode down-count from 00:03.
    cyc(0, 0, 1, 8'h00, 8'h03);
    cyc(1, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("fast2", 8'h00, 8'h01, 1'b0, 1'b0);
    cyc(1, 0, 0, 8'h00, 8'h00);
    lit("fast3", 8'h00, 8'h00, 1'b0, 1'b1);

    // Hold: no tick, no load, no change.
    cyc(0, 1, 0, 8'h00, 8'h00);
    lit("hold", 8'h00, 8'h00, 1'b0, 1'b1);

    // Async reset mid-cycle at 12:34.
    cyc(0, 0, 1, 8'h12, 8'h34);
    lit("ld1234", 8'h12, 8'h34, 1'b0, 1'b0);
    idle();
    #2;
    reset = 1'b1;
    #1;
    lit("asyncrst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("resume", 8'h00, 8'h01, 1'b0, 1'b0);

    // Reset while wrap is high clears it.
    cyc(0, 1, 1, 8'h59, 8'h59);
    cyc(1, 1, 0, 8'h00, 8'h00);
    lit("wrap2", 8'h00, 8'h00, 1'b1, 1'b0);
    idle();
    #1;
    reset = 1'b1;
    #1;
    lit("wraprst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Mixed stimulus checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom));
    end

    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
